// File: rtl/adc_pkg.sv
// adc_pkg: shared types and constants for the AD7928-style scan controller.
//   state_t      - scan FSM states
//   FRAME_BITS   - SPI frame length
//   NUM_CH       - ADC channel count
//   CW_*         - control-word field positions
//   DO_*         - returned DOUT frame field positions
//   ctrl_word()  - builds the 16-bit control word for a channel address
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_QUIET
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int NUM_CH     = 8;
    localparam int ADD_W      = 3;
    localparam int DATA_W     = 12;

    // Control word layout (DIN)
    localparam int CW_WRITE   = 15;
    localparam int CW_SEQ     = 14;
    localparam int CW_ADD_LSB = 10;
    localparam int CW_PM_LSB  = 8;
    localparam int CW_SHADOW  = 7;
    localparam int CW_RANGE   = 5;
    localparam int CW_CODING  = 4;

    // Returned frame layout (DOUT)
    localparam int DO_ADD_LSB = 12;

    // WRITE=1, SEQ=0, PM=11 (normal operation), SHADOW=0, CODING=1 (straight binary).
    function automatic logic [FRAME_BITS-1:0] ctrl_word(input logic [ADD_W-1:0] add,
                                                       input logic range_2x);
        logic [FRAME_BITS-1:0] w;
        w                          = '0;
        w[CW_WRITE]                = 1'b1;
        w[CW_SEQ]                  = 1'b0;
        w[CW_ADD_LSB +: ADD_W]     = add;
        w[CW_PM_LSB +: 2]          = 2'b11;
        w[CW_SHADOW]               = 1'b0;
        w[CW_RANGE]                = range_2x;
        w[CW_CODING]               = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/adc_rr_pick.sv
// adc_rr_pick: combinational round-robin next-channel selection.
//   scan_mask  in  channel enable bits, bit n = channel n
//   prev_add   in  previously programmed channel address
//   next_add   out lowest enabled channel above prev_add, else lowest enabled
// With an all-zero mask the output is 0; the caller never starts a frame then.
module adc_rr_pick
    import adc_pkg::*;
(
    input  logic [NUM_CH-1:0] scan_mask,
    input  logic [ADD_W-1:0]  prev_add,
    output logic [ADD_W-1:0]  next_add
);

    logic [ADD_W-1:0] lowest;
    logic [ADD_W-1:0] above;
    logic             found;

    // Both scans run high-to-low so the last hit is the lowest qualifying bit.
    always_comb begin
        lowest = '0;
        above  = '0;
        found  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (scan_mask[i]) lowest = ADD_W'(i);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (scan_mask[i] && (ADD_W'(i) > prev_add)) begin
                above = ADD_W'(i);
                found = 1'b1;
            end
        end
        next_add = found ? above : lowest;
    end

endmodule

// File: rtl/adc_scan_controller.sv
// adc_scan_controller: round-robin scan of an 8-channel SPI ADC (AD7928-style).
// Each frame programs the next enabled channel and captures the conversion of
// the channel programmed in the previous frame; the first frame after IDLE is
// a prime frame whose result is dropped.
//
// Optional feature macro: ADC_ADDR_CHECK_EN
//   defined   - returned address is compared to the expected channel; on
//               mismatch addr_err pulses and the sample is dropped.
//   undefined - returned address ignored, addr_err held low.
//
// Ports:
//   clock, reset       system clock, async active-high reset
//   enable             level, scanning runs while high
//   scan_mask[7:0]     channel enable bits (sampled at each frame start)
//   ADC_CS_N/SCLK/DIN  registered ADC pin outputs (SCLK idles high)
//   ADC_DOUT           ADC serial data in, MSB first
//   sample_data[11:0]  last accepted conversion
//   sample_ch[2:0]     channel of sample_data
//   sample_valid       one-cycle strobe with new sample
//   addr_err           one-cycle strobe, returned address mismatch
//   busy               frame start until end of the final quiet period
module adc_scan_controller
    import adc_pkg::*;
#(
    parameter int   SCLK_DIV  = 25,
    parameter int   QUIET_CYC = 50,
    parameter logic RANGE_2X  = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] scan_mask,
    output logic              ADC_CS_N,
    output logic              ADC_SCLK,
    output logic              ADC_DIN,
    input  logic              ADC_DOUT,
    output logic [DATA_W-1:0] sample_data,
    output logic [ADD_W-1:0]  sample_ch,
    output logic              sample_valid,
    output logic              addr_err,
    output logic              busy
);

    localparam int CNT_MAX = (SCLK_DIV > QUIET_CYC) ? SCLK_DIV : QUIET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SCLK_LAST  = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  half;      // 0: SCLK low half, 1: SCLK high half
    logic [3:0]            bit_idx;
    logic [FRAME_BITS-1:0] tx;
    logic [FRAME_BITS-1:0] rx;
    logic [ADD_W-1:0]      cur_add;   // address programmed in the current frame
    logic [ADD_W-1:0]      exp_ch;    // address whose conversion this frame returns
    logic                  prime;
    logic [ADD_W-1:0]      pick;
    logic                  go;

    assign go = enable && (scan_mask != '0);

    adc_rr_pick u_pick (
        .scan_mask (scan_mask),
        .prev_add  (cur_add),
        .next_add  (pick)
    );

`ifdef ADC_ADDR_CHECK_EN
    logic unused_rx;
    assign unused_rx = rx[FRAME_BITS-1];
`else
    logic unused_rx;
    assign unused_rx = ^rx[FRAME_BITS-1:DATA_W];
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            half         <= 1'b0;
            bit_idx      <= '0;
            tx           <= '0;
            rx           <= '0;
            cur_add      <= ADD_W'(NUM_CH - 1);
            exp_ch       <= '0;
            prime        <= 1'b0;
            ADC_CS_N     <= 1'b1;
            ADC_SCLK     <= 1'b1;
            ADC_DIN      <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            addr_err     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            addr_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state    <= ST_SETUP;
                        cnt      <= '0;
                        ADC_CS_N <= 1'b0;
                        busy     <= 1'b1;
                        prime    <= 1'b1;
                        exp_ch   <= cur_add;
                        cur_add  <= pick;
                        tx       <= ctrl_word(pick, RANGE_2X);
                    end
                end

                ST_SETUP: begin
                    if (cnt == SCLK_LAST) begin
                        // First falling SCLK edge presents bit 15.
                        state    <= ST_SHIFT;
                        cnt      <= '0;
                        half     <= 1'b0;
                        bit_idx  <= 4'(FRAME_BITS - 1);
                        ADC_SCLK <= 1'b0;
                        ADC_DIN  <= tx[FRAME_BITS-1];
                        tx       <= {tx[FRAME_BITS-2:0], 1'b0};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (cnt != SCLK_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (!half) begin
                        cnt      <= '0;
                        half     <= 1'b1;
                        ADC_SCLK <= 1'b1;
                        rx       <= {rx[FRAME_BITS-2:0], ADC_DOUT};
                    end else if (bit_idx != '0) begin
                        cnt      <= '0;
                        half     <= 1'b0;
                        bit_idx  <= bit_idx - 1'b1;
                        ADC_SCLK <= 1'b0;
                        ADC_DIN  <= tx[FRAME_BITS-1];
                        tx       <= {tx[FRAME_BITS-2:0], 1'b0};
                    end else begin
                        // Frame done: rx already holds all 16 bits.
                        state    <= ST_QUIET;
                        cnt      <= '0;
                        ADC_CS_N <= 1'b1;
                        ADC_DIN  <= 1'b0;
                        if (!prime) begin
`ifdef ADC_ADDR_CHECK_EN
                            if (rx[DO_ADD_LSB +: ADD_W] != exp_ch) begin
                                addr_err <= 1'b1;
                            end else begin
                                sample_valid <= 1'b1;
                                sample_data  <= rx[DATA_W-1:0];
                                sample_ch    <= exp_ch;
                            end
`else
                            sample_valid <= 1'b1;
                            sample_data  <= rx[DATA_W-1:0];
                            sample_ch    <= exp_ch;
`endif
                        end
                    end
                end

                ST_QUIET: begin
                    if (cnt != QUIET_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (go) begin
                        state    <= ST_SETUP;
                        cnt      <= '0;
                        ADC_CS_N <= 1'b0;
                        prime    <= 1'b0;
                        exp_ch   <= cur_add;
                        cur_add  <= pick;
                        tx       <= ctrl_word(pick, RANGE_2X);
                    end else begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_controller.sv
// tb_adc_scan_controller: directed bench for adc_scan_controller with a
// cycle-sampled ADC model. The model returns, in each frame, the conversion
// of the address captured from DIN in the previous frame; data = data_of(ch).
`timescale 1ns/1ps
module tb_adc_scan_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  scan_mask = 8'h00;
    logic        ADC_CS_N, ADC_SCLK, ADC_DIN;
    logic        ADC_DOUT = 1'b0;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sample_valid, addr_err, busy;

    adc_scan_controller dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .scan_mask    (scan_mask),
        .ADC_CS_N     (ADC_CS_N),
        .ADC_SCLK     (ADC_SCLK),
        .ADC_DIN      (ADC_DIN),
        .ADC_DOUT     (ADC_DOUT),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .addr_err     (addr_err),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [11:0] data_of(input logic [2:0] ch);
        return 12'hABC ^ {9'd0, ch};
    endfunction

    // ---------------- ADC model (edges detected one clock late) ----------
    logic        p_cs = 1'b1, p_sclk = 1'b1;
    logic [15:0] resp = 16'h0;
    logic [15:0] din_cap = 16'h0;
    logic [2:0]  mdl_prev = 3'd0;
    logic        bad = 1'b0;
    int          bitn = 0;
    logic [15:0] din_q[$];

    always @(posedge clock) begin
        p_cs   <= ADC_CS_N;
        p_sclk <= ADC_SCLK;
        if (p_cs && !ADC_CS_N) begin
            resp    <= {1'b0, (bad ? mdl_prev + 3'd1 : mdl_prev), data_of(mdl_prev)};
            bitn    <= 0;
            din_cap <= 16'h0;
        end
        if (!ADC_CS_N && p_sclk && !ADC_SCLK) begin
            ADC_DOUT <= resp[4'(15 - bitn)];
            bitn     <= bitn + 1;
        end
        if (!ADC_CS_N && !p_sclk && ADC_SCLK)
            din_cap <= {din_cap[14:0], ADC_DIN};
        if (!p_cs && ADC_CS_N) begin
            din_q.push_back(din_cap);
            mdl_prev <= din_cap[12:10];
        end
    end

    // ---------------- output monitor ----------------
    int          cyc = 0;
    logic [2:0]  v_ch[$];
    logic [11:0] v_data[$];
    int          v_cyc[$];
    int          n_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (sample_valid) begin
            v_ch.push_back(sample_ch);
            v_data.push_back(sample_data);
            v_cyc.push_back(cyc);
        end
        if (addr_err) n_err++;
    end

    // ---------------- checking helpers ----------------
    int n_pass = 0, n_total = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] din_at(input int i);
        return (din_q.size() > i) ? din_q[i] : 16'hxxxx;
    endfunction
    function automatic logic [2:0] vch_at(input int i);
        return (v_ch.size() > i) ? v_ch[i] : 3'bxxx;
    endfunction
    function automatic logic [11:0] vdata_at(input int i);
        return (v_data.size() > i) ? v_data[i] : 12'hxxx;
    endfunction
    function automatic int vcyc_at(input int i);
        return (v_cyc.size() > i) ? v_cyc[i] : -1;
    endfunction

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_busy(output int t);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (busy) break;
        end
        check("busy_rise_timeout", busy, 1);
        t = cyc;
    endtask

    task automatic wait_nvalid(input int n, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (v_ch.size() >= n) break;
            @(negedge clock);
        end
        check("valid_timeout", v_ch.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!busy) break;
            @(negedge clock);
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0, t1, vb, db, eb;
        logic [15:0] w;
        logic [2:0]  add_exp[5];
        logic [2:0]  ch_exp[4];
        logic        cs_low_seen;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_cs_n", ADC_CS_N, 1);
        check("rst_sclk", ADC_SCLK, 1);
        check("rst_din", ADC_DIN, 0);
        check("rst_data", sample_data, 0);
        check("rst_ch", sample_ch, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_busy", busy, 0);

        // Single channel: prime frame, then first sample 1700 cycles after start
        do_reset();
        scan_mask = 8'h01;
        db = din_q.size(); vb = v_ch.size();
        enable = 1'b1;
        wait_busy(t0);
        wait_nvalid(vb + 1, 2500);
        check("t1_valid_cycle", vcyc_at(vb) - t0, 1700);
        check("t1_data", vdata_at(vb), 12'hABC);
        check("t1_ch", vch_at(vb), 0);
        enable = 1'b0;
        wait_idle(1000);
        repeat (3) @(negedge clock);
        check("t1_din_ch0", din_at(db), 16'h8310);

        // Mask 0x25: round-robin 0,2,5,0,2
        do_reset();
        scan_mask = 8'h25;
        db = din_q.size(); vb = v_ch.size(); eb = n_err;
        enable = 1'b1;
        wait_busy(t0);
        wait_nvalid(vb + 4, 6000);
        enable = 1'b0;
        repeat (5) @(negedge clock);
        add_exp = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd2};
        ch_exp  = '{3'd0, 3'd2, 3'd5, 3'd0};
        for (int i = 0; i < 5; i++) begin
            w = din_at(db + i);
            check($sformatf("t2_add%0d", i), w[12:10], add_exp[i]);
        end
        check("t2_din_ch5", din_at(db + 2), 16'h9710);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_ch%0d", i), vch_at(vb + i), ch_exp[i]);
        check("t2_data_ch5", vdata_at(vb + 2), data_of(3'd5));
        check("t2_period", vcyc_at(vb + 1) - vcyc_at(vb), 875);
        check("t2_no_addr_err", n_err - eb, 0);
        wait_idle(1000);

        // Returned address mismatch (expected ch2, model returns 3)
        do_reset();
        scan_mask = 8'h04;
        bad = 1'b1;
        enable = 1'b1;
        wait_busy(t0);
        wait_cyc(t0 + 1700);
`ifdef ADC_ADDR_CHECK_EN
        check("t3_addr_err", addr_err, 1);
        check("t3_valid", sample_valid, 0);
        check("t3_data_hold", sample_data, 0);
        check("t3_ch_hold", sample_ch, 0);
`else
        check("t3_addr_err", addr_err, 0);
        check("t3_valid", sample_valid, 1);
        check("t3_ch", sample_ch, 2);
        check("t3_data", sample_data, data_of(3'd2));
`endif
        @(negedge clock);
        check("t3_err_1cyc", addr_err, 0);
        check("t3_valid_1cyc", sample_valid, 0);
        enable = 1'b0;
        bad = 1'b0;
        wait_idle(1000);

        // enable dropped mid-SHIFT of frame 2
        do_reset();
        scan_mask = 8'h01;
        enable = 1'b1;
        wait_busy(t0);
        wait_cyc(t0 + 875 + 400);
        enable = 1'b0;
        wait_cyc(t0 + 1700);
        check("t4_valid", sample_valid, 1);
        check("t4_data", sample_data, 12'hABC);
        check("t4_cs_high", ADC_CS_N, 1);
        wait_cyc(t0 + 1749);
        check("t4_busy_before", busy, 1);
        wait_cyc(t0 + 1750);
        check("t4_busy_fall", busy, 0);
        cs_low_seen = 1'b0;
        repeat (900) begin
            @(negedge clock);
            if (!ADC_CS_N) cs_low_seen = 1'b1;
        end
        check("t4_no_new_frame", cs_low_seen, 0);

        // Mask change 0x01 -> 0x80 mid-frame, then -> 0
        do_reset();
        scan_mask = 8'h01;
        db = din_q.size(); vb = v_ch.size();
        enable = 1'b1;
        wait_busy(t0);
        wait_cyc(t0 + 400);
        scan_mask = 8'h80;
        wait_cyc(t0 + 875 + 400);
        scan_mask = 8'h00;
        wait_idle(2000);
        repeat (3) @(negedge clock);
        check("t5_frames", din_q.size() - db, 2);
        check("t5_din_ch7", din_at(db + 1), 16'h9F10);
        check("t5_nvalid", v_ch.size() - vb, 1);
        check("t5_ch", vch_at(vb), 0);
        enable = 1'b0;

        // Reset mid-SHIFT of a non-prime frame
        do_reset();
        scan_mask = 8'h01;
        enable = 1'b1;
        wait_busy(t0);
        wait_cyc(t0 + 875 + 400);
        vb = v_ch.size();
        reset = 1'b1;
        #1;
        check("t6_cs_n", ADC_CS_N, 1);
        check("t6_sclk", ADC_SCLK, 1);
        check("t6_busy", busy, 0);
        wait_cyc(t0 + 1760);
        check("t6_no_strobe", v_ch.size() - vb, 0);
        reset = 1'b0;
        wait_busy(t1);
        wait_nvalid(vb + 1, 2500);
        check("t6_prime_again", vcyc_at(vb) - t1, 1700);
        enable = 1'b0;
        wait_idle(1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
